// File: rtl/obstacle_pkg.sv
// Shared constants and state encoding for the obstacle demo sprite engine.
package obstacle_pkg;

   localparam int DEF_WIDTH  = 160;
   localparam int DEF_HEIGHT = 120;

   localparam logic [2:0] BG  = 3'b000;
   localparam logic [2:0] DOT = 3'b010;

   typedef enum logic [3:0] {
      DRAW,
      DELAY,
      PROBE_X,
      WAIT_X,
      CHECK_X,
      PROBE_Y,
      WAIT_Y,
      CHECK_Y,
      PROBE_D,
      WAIT_D,
      CHECK_D,
      ERASE
   } state_t;

endpackage

// File: rtl/delay_timer.sv
// Down-counter that pulses done on the last of DELAY_CYCLES cycles after a start pulse.
module delay_timer #(
   parameter int DELAY_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic start,
   output logic done
);

   localparam int CW = $clog2(DELAY_CYCLES + 1);
   localparam logic [CW-1:0] LOAD = CW'(DELAY_CYCLES);
   localparam logic [CW-1:0] ONE  = CW'(1);

   logic [CW-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= '0;
      end else if (start) begin
         count_reg <= LOAD;
      end else if (count_reg != '0) begin
         count_reg <= count_reg - ONE;
      end
   end

   assign done = (count_reg == ONE);

endmodule

// File: rtl/obstacle_processor.sv
// Bouncing-dot sprite engine: probes neighbours in the frame buffer, reflects off edges
// and obstacles, and erases/redraws the dot through the processor port.
module obstacle_processor
   import obstacle_pkg::*;
#(
   parameter int         WIDTH        = DEF_WIDTH,
   parameter int         HEIGHT       = DEF_HEIGHT,
   parameter int         START_X      = 10,
   parameter int         START_Y      = 10,
   parameter logic [2:0] DOT_COLOR    = DOT,
   parameter logic [2:0] BG_COLOR     = BG,
   parameter int         DELAY_CYCLES = 16
) (
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] plot_color,
   output logic       plot,
   input  logic [2:0] image_color
);

   localparam logic signed [8:0] X_MAX = 9'(WIDTH - 1);
   localparam logic signed [8:0] Y_MAX = 9'(HEIGHT - 1);

   state_t      state_reg, state_next;
   logic [7:0]  pos_x_reg, pos_x_next;
   logic [6:0]  pos_y_reg, pos_y_next;
   logic        dx_neg_reg, dx_neg_next;
   logic        dy_neg_reg, dy_neg_next;
   logic [7:0]  x_reg, x_next;
   logic [6:0]  y_reg, y_next;
   logic [2:0]  color_reg, color_next;
   logic        plot_reg, plot_next;

   logic signed [8:0] tx, ty;
   logic        x_oob, y_oob, obstacle;
   logic        timer_start, timer_done;

   // Targets are widened to 9-bit signed so a step off either edge shows up as <0 or >MAX.
   assign tx = $signed({1'b0, pos_x_reg}) + (dx_neg_reg ? -9'sd1 : 9'sd1);
   assign ty = $signed({2'b00, pos_y_reg}) + (dy_neg_reg ? -9'sd1 : 9'sd1);
   assign x_oob    = tx[8] || (tx > X_MAX);
   assign y_oob    = ty[8] || (ty > Y_MAX);
   assign obstacle = (image_color != BG_COLOR);

   assign timer_start = (state_next == DELAY) && (state_reg != DELAY);

   delay_timer #(
      .DELAY_CYCLES(DELAY_CYCLES)
   ) u_delay_timer (
      .clk  (clk),
      .reset(reset),
      .start(timer_start),
      .done (timer_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg  <= DRAW;
         pos_x_reg  <= 8'(START_X);
         pos_y_reg  <= 7'(START_Y);
         dx_neg_reg <= 1'b0;
         dy_neg_reg <= 1'b0;
         x_reg      <= 8'(START_X);
         y_reg      <= 7'(START_Y);
         color_reg  <= BG_COLOR;
         plot_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         pos_x_reg  <= pos_x_next;
         pos_y_reg  <= pos_y_next;
         dx_neg_reg <= dx_neg_next;
         dy_neg_reg <= dy_neg_next;
         x_reg      <= x_next;
         y_reg      <= y_next;
         color_reg  <= color_next;
         plot_reg   <= plot_next;
      end
   end

   // Address registers default to hold, which keeps the read address stable through WAIT/CHECK.
   always_comb begin
      state_next  = state_reg;
      pos_x_next  = pos_x_reg;
      pos_y_next  = pos_y_reg;
      dx_neg_next = dx_neg_reg;
      dy_neg_next = dy_neg_reg;
      x_next      = x_reg;
      y_next      = y_reg;
      color_next  = BG_COLOR;
      plot_next   = 1'b0;
      case (state_reg)
         DRAW: begin
            plot_next  = 1'b1;
            x_next     = pos_x_reg;
            y_next     = pos_y_reg;
            color_next = DOT_COLOR;
            state_next = DELAY;
         end
         DELAY: begin
            if (timer_done) state_next = PROBE_X;
         end
         PROBE_X: begin
            if (x_oob) begin
               dx_neg_next = ~dx_neg_reg;
               state_next  = PROBE_Y;
            end else begin
               x_next     = tx[7:0];
               y_next     = pos_y_reg;
               state_next = WAIT_X;
            end
         end
         WAIT_X: state_next = CHECK_X;
         CHECK_X: begin
            if (obstacle) dx_neg_next = ~dx_neg_reg;
            state_next = PROBE_Y;
         end
         PROBE_Y: begin
            if (y_oob) begin
               dy_neg_next = ~dy_neg_reg;
               state_next  = PROBE_D;
            end else begin
               x_next     = pos_x_reg;
               y_next     = ty[6:0];
               state_next = WAIT_Y;
            end
         end
         WAIT_Y: state_next = CHECK_Y;
         CHECK_Y: begin
            if (obstacle) dy_neg_next = ~dy_neg_reg;
            state_next = PROBE_D;
         end
         PROBE_D: begin
            if (x_oob || y_oob) begin
               dx_neg_next = ~dx_neg_reg;
               dy_neg_next = ~dy_neg_reg;
               state_next  = DELAY;
            end else begin
               x_next     = tx[7:0];
               y_next     = ty[6:0];
               state_next = WAIT_D;
            end
         end
         WAIT_D: state_next = CHECK_D;
         CHECK_D: begin
            if (obstacle) begin
               dx_neg_next = ~dx_neg_reg;
               dy_neg_next = ~dy_neg_reg;
               state_next  = DELAY;
            end else begin
               state_next = ERASE;
            end
         end
         ERASE: begin
            plot_next  = 1'b1;
            x_next     = pos_x_reg;
            y_next     = pos_y_reg;
            color_next = BG_COLOR;
            pos_x_next = tx[7:0];
            pos_y_next = ty[6:0];
            state_next = DRAW;
         end
         default: state_next = DRAW;
      endcase
   end

   assign x          = x_reg;
   assign y          = y_reg;
   assign plot_color = color_reg;
   assign plot       = plot_reg;

endmodule

// File: tb/tb_obstacle_processor.sv
// Bench for obstacle_processor: behavioural frame buffer, write capture, and a rule-level
// model of the bouncing dot predicting the ordered sequence of frame-buffer writes.
module tb_obstacle_processor;
   import obstacle_pkg::*;

   localparam int W = 160;
   localparam int H = 120;
   localparam logic [2:0] DOT_C = 3'b010;
   localparam logic [2:0] BG_C  = 3'b000;

   typedef struct packed {
      logic [7:0] px;
      logic [6:0] py;
      logic [2:0] c;
   } wr_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] plot_color;
   logic       plot;
   logic [2:0] image_color;

   logic [7:0] x2;
   logic [6:0] y2;
   logic [2:0] pc2;
   logic       plot2;
   logic [2:0] img2 = 3'b000;

   always #5 clk = ~clk;

   obstacle_processor #(
      .WIDTH(W), .HEIGHT(H), .START_X(10), .START_Y(10),
      .DOT_COLOR(DOT_C), .BG_COLOR(BG_C), .DELAY_CYCLES(4)
   ) dut (
      .clk(clk), .reset(reset), .x(x), .y(y), .plot_color(plot_color),
      .plot(plot), .image_color(image_color)
   );

   obstacle_processor #(
      .WIDTH(W), .HEIGHT(H), .START_X(159), .START_Y(10),
      .DOT_COLOR(DOT_C), .BG_COLOR(BG_C), .DELAY_CYCLES(4)
   ) dut_edge (
      .clk(clk), .reset(reset), .x(x2), .y(y2), .plot_color(pc2),
      .plot(plot2), .image_color(img2)
   );

   // Frame buffer with registered read, plus bench-side clear/load access.
   logic [2:0] mem [W][H];
   logic       clear_req = 1'b0;
   logic       load_en = 1'b0;
   logic [7:0] load_x = '0;
   logic [6:0] load_y = '0;
   logic [2:0] load_c = '0;

   always @(posedge clk) begin
      if (clear_req) begin
         for (int i = 0; i < W; i++)
            for (int j = 0; j < H; j++)
               mem[i][j] <= BG_C;
      end else if (load_en) begin
         mem[int'(load_x)][int'(load_y)] <= load_c;
      end else if (plot && int'(x) < W && int'(y) < H) begin
         mem[int'(x)][int'(y)] <= plot_color;
      end
      if (int'(x) < W && int'(y) < H) image_color <= mem[int'(x)][int'(y)];
      else image_color <= BG_C;
   end

   wr_t cap_q[$];
   wr_t cap2_q[$];

   always @(posedge clk) begin
      if (plot)  cap_q.push_back(wr_t'{x, y, plot_color});
      if (plot2) cap2_q.push_back(wr_t'{x2, y2, pc2});
   end

   // Reference model: image, dot position/direction, pending expected writes.
   logic [2:0] mimg [W][H];
   int  m_x, m_y, m_dx, m_dy;
   wr_t exp_q[$];

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic wr_t mk(input int px, input int py, input logic [2:0] c);
      return wr_t'{8'(px), 7'(py), c};
   endfunction

   function automatic bit blocked(input int px, input int py);
      if (px < 0 || px >= W || py < 0 || py >= H) return 1'b1;
      return mimg[px][py] != BG_C;
   endfunction

   task automatic m_step();
      if (blocked(m_x + m_dx, m_y)) m_dx = -m_dx;
      if (blocked(m_x, m_y + m_dy)) m_dy = -m_dy;
      if (blocked(m_x + m_dx, m_y + m_dy)) begin
         m_dx = -m_dx;
         m_dy = -m_dy;
      end else begin
         exp_q.push_back(mk(m_x, m_y, BG_C));
         m_x = m_x + m_dx;
         m_y = m_y + m_dy;
         exp_q.push_back(mk(m_x, m_y, DOT_C));
      end
   endtask

   task automatic hold_reset(input bit clear);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      if (clear) begin
         clear_req = 1'b1;
         @(negedge clk);
         clear_req = 1'b0;
         for (int i = 0; i < W; i++)
            for (int j = 0; j < H; j++)
               mimg[i][j] = BG_C;
      end
   endtask

   task automatic place(input int px, input int py, input logic [2:0] c);
      load_x = 8'(px);
      load_y = 7'(py);
      load_c = c;
      load_en = 1'b1;
      @(negedge clk);
      load_en = 1'b0;
      mimg[px][py] = c;
   endtask

   task automatic release_reset(input int sx, input int sy);
      reset = 1'b0;
      cap_q.delete();
      cap2_q.delete();
      m_x = sx;
      m_y = sy;
      m_dx = 1;
      m_dy = 1;
      exp_q.delete();
      exp_q.push_back(mk(sx, sy, DOT_C));
   endtask

   task automatic expect_writes(input int n, input string name);
      int  guard;
      wr_t got;
      wr_t want;
      for (int k = 0; k < n; k++) begin
         guard = 0;
         while (exp_q.size() == 0 && guard < 8) begin
            m_step();
            guard++;
         end
         if (exp_q.size() == 0) begin
            repeat (300) @(negedge clk);
            check($sformatf("%s_enclosed_quiet", name), 32'(cap_q.size()), 32'd0);
            return;
         end
         for (int t = 0; t < 400 && cap_q.size() == 0; t++) @(negedge clk);
         if (cap_q.size() == 0) begin
            check($sformatf("%s_timeout%0d", name, k), 32'(cap_q.size()), 32'd1);
            return;
         end
         got  = cap_q.pop_front();
         want = exp_q.pop_front();
         check($sformatf("%s_wr%0d", name, k), 32'(got), 32'(want));
         mimg[int'(want.px)][int'(want.py)] = want.c;
      end
   endtask

   initial begin
      int  nobs;
      int  ox;
      int  oy;
      wr_t e2 [3];

      // Blank image, reset state and the first draw one cycle after release.
      hold_reset(1'b1);
      check("rst_plot",  32'(plot), 32'd0);
      check("rst_x",     32'(x), 32'd10);
      check("rst_y",     32'(y), 32'd10);
      check("rst_color", 32'(plot_color), 32'(BG_C));
      release_reset(10, 10);
      @(negedge clk);
      check("first_draw", 32'({plot, x, y, plot_color}), 32'({1'b1, 8'd10, 7'd10, DOT_C}));
      expect_writes(3, "blank");

      // Start at the right edge: X probe out of bounds.
      for (int t = 0; t < 200 && cap2_q.size() < 3; t++) @(negedge clk);
      check("edge_count", 32'(cap2_q.size() >= 3), 32'd1);
      e2[0] = mk(159, 10, DOT_C);
      e2[1] = mk(159, 10, BG_C);
      e2[2] = mk(158, 11, DOT_C);
      for (int k = 0; k < 3; k++)
         if (k < cap2_q.size())
            check($sformatf("edge_wr%0d", k), 32'(cap2_q[k]), 32'(e2[k]));

      // Obstacle beside the dot flips dx.
      hold_reset(1'b1);
      place(11, 10, 3'b100);
      release_reset(10, 10);
      expect_writes(3, "obstx");
      check("obstx_kept", 32'(mem[11][10]), 32'd4);

      // Diagonal-only obstacle: no move that iteration, then run into the (0,0) corner and out.
      hold_reset(1'b1);
      place(11, 11, 3'b101);
      release_reset(10, 10);
      expect_writes(23, "diag");
      check("diag_kept", 32'(mem[11][11]), 32'd5);

      // Reset during ERASE: erase is suppressed, left-over dot becomes an obstacle.
      hold_reset(1'b1);
      release_reset(10, 10);
      expect_writes(3, "pre");
      for (int t = 0; t < 200 && dut.state_reg != ERASE; t++) @(negedge clk);
      check("erase_reached", 32'(dut.state_reg == ERASE), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      check("rst_in_erase_plot", 32'(plot), 32'd0);
      release_reset(10, 10);
      expect_writes(5, "after_rst");

      // Fully enclosed dot never moves.
      hold_reset(1'b1);
      for (int i = -1; i <= 1; i++)
         for (int j = -1; j <= 1; j++)
            if (i != 0 || j != 0) place(10 + i, 10 + j, 3'($urandom_range(1, 7)));
      release_reset(10, 10);
      expect_writes(3, "encl");

      // Randomised obstacle fields.
      for (int tr = 0; tr < 6; tr++) begin
         hold_reset(1'b1);
         nobs = $urandom_range(20, 60);
         for (int k = 0; k < nobs; k++) begin
            ox = $urandom_range(0, 40);
            oy = $urandom_range(0, 40);
            if (!(ox == 10 && oy == 10)) place(ox, oy, 3'($urandom_range(1, 7)));
         end
         release_reset(10, 10);
         expect_writes(30, $sformatf("rnd%0d", tr));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
